// File: rtl/imem_fetch_pkg.sv
// ============================================================================
// Module  : imem_fetch_pkg
// Brief   : Shared state encoding, fault codes and word geometry for the
//           byte-wide instruction fetch sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_fetch_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_RANGE    = 2'b10;

   localparam int BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/imem_fetch_ctrl_if.sv
// ============================================================================
// Module  : imem_fetch_ctrl_if
// Brief   : Memory, decode-handshake and redirect signals of the fetch block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_fetch_ctrl_if #(
   parameter int ADDR_W = 7
);
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halted;
   logic [1:0]        fault;

   // master = the fetch sequencer; slave = memory plus decode/branch unit
   modport master (
      output mem_addr, instr, instr_pc, instr_valid, halted, fault,
      input  mem_rdata, instr_ready, redirect, redirect_pc
   );

   modport slave (
      input  mem_addr, instr, instr_pc, instr_valid, halted, fault,
      output mem_rdata, instr_ready, redirect, redirect_pc
   );
endinterface

`default_nettype wire

// File: rtl/imem_fetch_ctrl_be_word_assembler.sv
// ============================================================================
// Module  : be_word_assembler
// Brief   : Collects four bytes into a big-endian 32-bit word register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module be_word_assembler (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic [1:0]  byte_idx,
   input  wire logic        capture,
   input  wire logic [7:0]  byte_in,
   output      logic [31:0] word
);

   logic [31:0] word_q;
   logic [31:0] word_d;

   // byte index 0 is the lowest address and lands in the top byte
   always_comb begin
      word_d = word_q;
      if (capture) begin
         case (byte_idx)
            2'd0:    word_d[31:24] = byte_in;
            2'd1:    word_d[23:16] = byte_in;
            2'd2:    word_d[15:8]  = byte_in;
            default: word_d[7:0]   = byte_in;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q <= 32'd0;
      end else begin
         word_q <= word_d;
      end
   end

   assign word = word_q;

endmodule

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// ============================================================================
// Module  : imem_fetch_ctrl
// Brief   : Instruction-fetch sequencer: walks a byte-wide synchronous memory,
//           assembles 32-bit words and presents them over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_ctrl
   import imem_fetch_pkg::*;
#(
   parameter int ADDR_W    = 7,
   parameter int MEM_BYTES = 76,
   parameter int RESET_PC  = 0
) (
   input  wire logic          clk,
   input  wire logic          reset,
   imem_fetch_ctrl_if.master  bus
);

   localparam int                AW1     = ADDR_W + 1;
   localparam logic [AW1-1:0]    LAST_PC = AW1'(MEM_BYTES - BYTES_PER_WORD);

   localparam logic [1:0] RST_FAULT =
      ((RESET_PC % BYTES_PER_WORD) != 0)       ? FAULT_MISALIGN :
      (RESET_PC > (MEM_BYTES - BYTES_PER_WORD)) ? FAULT_RANGE    : FAULT_NONE;
   localparam state_e RST_STATE = (RST_FAULT == FAULT_NONE) ? ST_FETCH : ST_HALT;
   localparam logic   RST_HALT  = (RST_FAULT != FAULT_NONE);

   // Checked one bit wider than the address so pc+4 cannot wrap into range
   function automatic logic [1:0] entry_fault(input logic [AW1-1:0] pc);
      if (pc[1:0] != 2'b00) begin
         return FAULT_MISALIGN;
      end else if (pc > LAST_PC) begin
         return FAULT_RANGE;
      end
      return FAULT_NONE;
   endfunction

   state_e            state_q,  state_d;
   logic [ADDR_W-1:0] pc_q,     pc_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [2:0]        cnt_q,    cnt_d;
   logic              valid_q,  valid_d;
   logic [ADDR_W-1:0] ipc_q,    ipc_d;
   logic [1:0]        fault_q,  fault_d;
   logic              halted_q, halted_d;

   logic              load_pc;
   logic [AW1-1:0]    new_pc;
   logic [1:0]        new_fault;
   logic              capture;
   logic [1:0]        byte_idx;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      ipc_d     = ipc_q;
      fault_d   = fault_q;
      halted_d  = halted_q;
      load_pc   = 1'b0;
      new_pc    = '0;
      new_fault = FAULT_NONE;
      capture   = 1'b0;
      byte_idx  = cnt_q[1:0] - 2'd1;

      if (bus.redirect) begin
         load_pc = 1'b1;
         new_pc  = {1'b0, bus.redirect_pc};
      end else begin
         case (state_q)
            ST_FETCH: begin
               // byte for address pc+cnt-1 arrives in cycle cnt
               capture = (cnt_q != 3'd0);
               if (cnt_q == 3'd4) begin
                  valid_d = 1'b1;
                  ipc_d   = pc_q;
                  cnt_d   = 3'd0;
                  state_d = ST_HOLD;
               end else begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q < 3'd3) begin
                     addr_d = pc_q + ADDR_W'(cnt_q) + ADDR_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (valid_q && bus.instr_ready) begin
                  load_pc = 1'b1;
                  new_pc  = {1'b0, pc_q} + AW1'(BYTES_PER_WORD);
               end
            end
            default: ;
         endcase
      end

      if (load_pc) begin
         new_fault = entry_fault(new_pc);
         pc_d      = new_pc[ADDR_W-1:0];
         addr_d    = new_pc[ADDR_W-1:0];
         cnt_d     = 3'd0;
         valid_d   = 1'b0;
         fault_d   = new_fault;
         halted_d  = (new_fault != FAULT_NONE);
         state_d   = (new_fault == FAULT_NONE) ? ST_FETCH : ST_HALT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= RST_STATE;
         pc_q     <= ADDR_W'(RESET_PC);
         addr_q   <= ADDR_W'(RESET_PC);
         cnt_q    <= 3'd0;
         valid_q  <= 1'b0;
         ipc_q    <= '0;
         fault_q  <= RST_FAULT;
         halted_q <= RST_HALT;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         ipc_q    <= ipc_d;
         fault_q  <= fault_d;
         halted_q <= halted_d;
      end
   end

   be_word_assembler u_asm (
      .clk      (clk),
      .reset    (reset),
      .byte_idx (byte_idx),
      .capture  (capture),
      .byte_in  (bus.mem_rdata),
      .word     (bus.instr)
   );

   assign bus.mem_addr    = addr_q;
   assign bus.instr_pc    = ipc_q;
   assign bus.instr_valid = valid_q;
   assign bus.halted      = halted_q;
   assign bus.fault       = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
// ============================================================================
// Module  : tb_imem_fetch_ctrl
// Brief   : Directed bench for imem_fetch_ctrl with a synchronous byte memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_ctrl;

   localparam int ADDR_W = 7;

   logic clk;
   logic reset;
   logic [7:0] mem [0:127];
   int checks;
   int errors;

   imem_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   imem_fetch_ctrl #(
      .ADDR_W    (ADDR_W),
      .MEM_BYTES (76),
      .RESET_PC  (0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

   function automatic logic [31:0] word_at(input int pc);
      return {mem[pc], mem[pc+1], mem[pc+2], mem[pc+3]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 128; i++) mem[i] = 8'((i * 13 + 1) & 8'hFF);
      mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;

      reset = 1'b1;
      bus.instr_ready = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      repeat (3) @(negedge clk);
      chk("rst_instr",  bus.instr, 32'd0);
      chk("rst_valid",  32'(bus.instr_valid), 32'd0);
      chk("rst_addr",   32'(bus.mem_addr), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_fault",  32'(bus.fault), 32'd0);

      // first fetch from pc 0
      reset = 1'b0;
      bus.instr_ready = 1'b1;
      chk("f0_addr0", 32'(bus.mem_addr), 32'd0);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk("f0_addr", 32'(bus.mem_addr), 32'(k));
      end
      @(negedge clk);
      chk("f0_addr_c4", 32'(bus.mem_addr), 32'd3);
      chk("f0_valid_c4", 32'(bus.instr_valid), 32'd0);
      @(negedge clk);
      chk("f0_valid", 32'(bus.instr_valid), 32'd1);
      chk("f0_instr", bus.instr, 32'h20080005);
      chk("f0_pc", 32'(bus.instr_pc), 32'd0);
      @(negedge clk);
      chk("f0_accept_valid", 32'(bus.instr_valid), 32'd0);
      chk("f0_next_addr", 32'(bus.mem_addr), 32'd4);

      // stall word at pc 4 for 10 cycles
      bus.instr_ready = 1'b0;
      repeat (5) @(negedge clk);
      chk("f4_valid", 32'(bus.instr_valid), 32'd1);
      chk("f4_instr", bus.instr, word_at(4));
      chk("f4_pc", 32'(bus.instr_pc), 32'd4);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("hold_valid", 32'(bus.instr_valid), 32'd1);
         chk("hold_instr", bus.instr, word_at(4));
         chk("hold_pc", 32'(bus.instr_pc), 32'd4);
         chk("hold_addr", 32'(bus.mem_addr), 32'd7);
      end
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      chk("hold_accept_valid", 32'(bus.instr_valid), 32'd0);
      chk("hold_next_addr", 32'(bus.mem_addr), 32'd8);

      // redirect to 20 during cycle 2 of the pc-8 fetch
      repeat (2) @(negedge clk);
      chk("f8_addr_c2", 32'(bus.mem_addr), 32'd10);
      bus.redirect = 1'b1;
      bus.redirect_pc = 7'd20;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk("redir_addr", 32'(bus.mem_addr), 32'd20);
      chk("redir_valid", 32'(bus.instr_valid), 32'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("redir_no_word", 32'(bus.instr_valid), 32'd0);
      end
      @(negedge clk);
      chk("f20_valid", 32'(bus.instr_valid), 32'd1);
      chk("f20_pc", 32'(bus.instr_pc), 32'd20);
      chk("f20_instr", bus.instr, word_at(20));

      // redirect to misaligned 6 together with a handshake
      bus.instr_ready = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_pc = 7'd6;
      @(negedge clk);
      bus.redirect = 1'b0;
      bus.instr_ready = 1'b0;
      chk("mis_halted", 32'(bus.halted), 32'd1);
      chk("mis_fault", 32'(bus.fault), 32'd1);
      chk("mis_valid", 32'(bus.instr_valid), 32'd0);
      chk("mis_addr", 32'(bus.mem_addr), 32'd6);
      repeat (3) @(negedge clk);
      chk("mis_addr_frozen", 32'(bus.mem_addr), 32'd6);
      chk("mis_fault_held", 32'(bus.fault), 32'd1);

      // recover at the last legal word, then step past the end
      bus.redirect = 1'b1;
      bus.redirect_pc = 7'd72;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk("rec_fault", 32'(bus.fault), 32'd0);
      chk("rec_halted", 32'(bus.halted), 32'd0);
      chk("rec_addr", 32'(bus.mem_addr), 32'd72);
      repeat (5) @(negedge clk);
      chk("f72_valid", 32'(bus.instr_valid), 32'd1);
      chk("f72_pc", 32'(bus.instr_pc), 32'd72);
      chk("f72_instr", bus.instr, word_at(72));
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      chk("rng_halted", 32'(bus.halted), 32'd1);
      chk("rng_fault", 32'(bus.fault), 32'd2);
      chk("rng_valid", 32'(bus.instr_valid), 32'd0);
      chk("rng_addr", 32'(bus.mem_addr), 32'd76);
      repeat (3) @(negedge clk);
      chk("rng_addr_frozen", 32'(bus.mem_addr), 32'd76);

      // asynchronous reset in cycle 3 of a fetch from 12
      bus.redirect = 1'b1;
      bus.redirect_pc = 7'd12;
      @(negedge clk);
      bus.redirect = 1'b0;
      repeat (3) @(negedge clk);
      chk("f12_addr_c3", 32'(bus.mem_addr), 32'd15);
      #2 reset = 1'b1;
      #1;
      chk("arst_instr", bus.instr, 32'd0);
      chk("arst_valid", 32'(bus.instr_valid), 32'd0);
      chk("arst_addr", 32'(bus.mem_addr), 32'd0);
      chk("arst_fault", 32'(bus.fault), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.instr_ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_valid", 32'(bus.instr_valid), 32'd1);
      chk("post_instr", bus.instr, 32'h20080005);
      chk("post_pc", 32'(bus.instr_pc), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer sitting between the CPU decode stage and the byte-organised instruction memory.
- The memory is 8-bit wide, synchronous-read and big-endian: four bytes make one 32-bit instruction.
- The block owns the PC, walks the memory one byte per cycle, assembles each word and hands it to decode over a valid/ready handshake.
- It handles branch/jump redirects and faults on misaligned or out-of-range fetches.

Parameters:
- ADDR_W, 7, byte-address width of the instruction memory.
- MEM_BYTES, 76, number of valid bytes in the instruction memory (addresses 0..MEM_BYTES-1).
- RESET_PC, 0, PC loaded on reset; must be a multiple of 4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_addr  output  ADDR_W  byte address to the instruction memory.
- mem_rdata  input  8  byte returned by memory, one cycle after its address.
- instr  output  32  assembled instruction, big-endian (byte at PC in [31:24]).
- instr_pc  output  ADDR_W  byte address of the word on instr.
- instr_valid  output  1  instr/instr_pc hold a complete word.
- instr_ready  input  1  decode accepts the word this cycle.
- redirect  input  1  load a new PC (branch/jump taken).
- redirect_pc  input  ADDR_W  target PC for redirect.
- halted  output  1  block is in HALT; no fetches are issued.
- fault  output  2  00 none, 01 misaligned PC, 10 PC out of range.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: pc=RESET_PC, mem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, fault=00, state=FETCH, byte counters=0. Reset takes effect immediately, including mid-fetch; any partial word is discarded.
- States:
  - FETCH: issue 4 byte reads and capture 4 bytes.
  - HOLD: complete word presented; wait for handshake.
  - HALT: faulted; idle.
- Fault check on FETCH entry (pc from reset, increment or redirect):
  - pc[1:0]!=0 -> HALT, fault=01.
  - Else pc > MEM_BYTES-4 -> HALT, fault=10.
  - Compare at ADDR_W+1 bits; no wrap-around.
  - In HALT: no memory accesses; mem_addr holds pc.
- FETCH timing, with k = cycle index from 0:
  - Cycle k (k=0..3): mem_addr = pc + k.
  - Cycle k (k=1..4): mem_rdata = byte pc+k-1, captured into instr[31-8(k-1) -: 8] at the end of the cycle.
  - At the end of cycle 4: instr_valid<=1, instr_pc<=pc, state<=HOLD.
  - Latency: 5 cycles from FETCH entry to instr_valid visible.
  - In cycle 4, mem_addr holds pc+3.
- HOLD:
  - instr, instr_pc, instr_valid and mem_addr are held stable while instr_ready=0.
  - On an edge with instr_valid & instr_ready: pc<=pc+4, instr_valid<=0, state<=FETCH, with the fault check applied to the new pc.
  - Sustained throughput: one instruction per 6 cycles.
- instr changes only on byte capture or reset. Decode must sample instr only while instr_valid=1.
- redirect has highest priority in every state. At the edge:
  - pc<=redirect_pc, instr_valid<=0, counters<=0, fault<=00, halted<=0, state<=FETCH; the fault check then applies to redirect_pc.
  - Any in-flight partial word is dropped, and no word from the old PC is ever presented.
- Redirect together with a valid&ready handshake in the same cycle: the presented word counts as accepted, and the redirect wins for the next PC (no +4).
- halted = (state==HALT). fault is held until redirect or reset. instr_ready is ignored when instr_valid=0.

Decomposition:
- Shared package imem_fetch_pkg:
  - State encoding (FETCH, HOLD, HALT).
  - Fault codes (FAULT_NONE=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10).
  - BYTES_PER_WORD=4.
- One natural sub-module, be_word_assembler:
  - Inputs: clk, reset, 2-bit byte index, capture strobe, 8-bit byte.
  - Output: 32-bit big-endian word register.
- The FSM, PC and fault check stay in imem_fetch_ctrl.

Test Plan:
- Memory bytes 0..3 = 20 08 00 05, instr_ready=1 after reset release -> mem_addr sequence 0,1,2,3; instr=32'h20080005, instr_pc=0, instr_valid high on the 5th edge after reset release; next fetch starts at pc 4.
- Hold instr_ready=0 for 10 cycles with a word valid -> instr, instr_pc, mem_addr stable and instr_valid=1 throughout; raise ready -> one handshake, next instr_pc=4.
- Assert redirect with redirect_pc=8 during FETCH cycle 2 of pc 0 -> no word with instr_pc=0 appears; next valid word has instr_pc=8 with bytes 8..11.
- redirect_pc=6 -> halted=1, fault=01, instr_valid=0, mem_addr frozen; then redirect_pc=12 -> fault=00 and fetch resumes.
- MEM_BYTES=76: fetch at pc 72 succeeds; handshake advances pc to 76 -> halted=1, fault=10, no further mem_addr changes.
- Assert reset asynchronously in FETCH cycle 3 -> instr=0, instr_valid=0, mem_addr=RESET_PC immediately, before the next clk edge; a clean fetch from RESET_PC follows release.
